bin_to_7seg_mux: RTL and testbench

Parametrised successor of the two-digit binary-to-7-segment decoder. Converts a WIDTH-bit unsigned value to DIGITS decimal digits with a sequential double-dabble engine, or passes it through as hexadecimal nibbles. Drives the digits two ways: as a static bus for boards with one HEX display per digit, and as a time-multiplexed segment/anode pair for scanned displays. Sits between datapath result registers and board display pins.

---
 rtl/seg7_pkg.sv | 54 +++++
 rtl/seg7_enc.sv | 23 ++
 rtl/bin_to_7seg_mux.sv | 202 ++++++++++++++++++++
 tb/tb_bin_to_7seg_mux.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and active-low glyph table for the 7-segment display path.
// Glyph bit order is gfedcba.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  function automatic logic [6:0] nib2seg(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = SEG_0;
      4'h1:    g = SEG_1;
      4'h2:    g = SEG_2;
      4'h3:    g = SEG_3;
      4'h4:    g = SEG_4;
      4'h5:    g = SEG_5;
      4'h6:    g = SEG_6;
      4'h7:    g = SEG_7;
      4'h8:    g = SEG_8;
      4'h9:    g = SEG_9;
      4'hA:    g = SEG_A;
      4'hB:    g = SEG_B;
      4'hC:    g = SEG_C;
      4'hD:    g = SEG_D;
      4'hE:    g = SEG_E;
      4'hF:    g = SEG_F;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_enc.sv
// One digit's glyph (active-low). A dash overrides blanking, which overrides the nibble.
module seg7_enc
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] glyph
);

  // Glyph select
  always_comb begin
    glyph = SEG_BLANK;
    if (dash) begin
      glyph = SEG_DASH;
    end else if (blank) begin
      glyph = SEG_BLANK;
    end else begin
      glyph = nib2seg(nibble);
    end
  end

endmodule

// File: rtl/bin_to_7seg_mux.sv
// Binary to DIGITS-digit display: sequential double-dabble (or raw hex), static
// per-digit segment bus and a scanned segment/anode pair.
module bin_to_7seg_mux
  import seg7_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int DIGITS         = 3,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      bin,
  input  logic                  start,
  input  logic                  hex_mode,
  input  logic                  blank_en,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   seg_all,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t              state_r, state_nxt_s;
  logic                load_s, shift_s, fin_s;
  logic [WIDTH-1:0]    shreg_r;
  logic [BW-1:0]       bcd_r, adj_s, disp_r;
  logic [CW-1:0]       cnt_r;
  logic                hex_r, ovf_acc_r, valid_r, ovf_r, done_r, busy_r;
  logic [BW+WIDTH-1:0] ext_s;
  logic                hex_ovf_s;
  logic [DIGITS-1:0]   blank_s;
  logic                zero_above_s;
  logic [6:0]          glyph_s [DIGITS];
  logic [6:0]          pglyph_s [DIGITS];
  logic [PW-1:0]       presc_r;
  logic [IW-1:0]       idx_r, idx_nxt_s;
  logic                tc_s;
  logic [6:0]          seg_r;
  logic [DIGITS-1:0]   an_r;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state and datapath strobes
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    shift_s     = 1'b0;
    fin_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s      = 1'b1;
          state_nxt_s = hex_mode ? DONE : SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        shift_s = 1'b1;
        if (cnt_r == CW'(1)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE: begin
        fin_s       = 1'b1;
        state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Add-3 correction of every BCD nibble ahead of the shift
  always_comb begin
    adj_s = bcd_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = bcd_r[4*i +: 4];
      end
    end
  end

  assign ext_s     = {{BW{1'b0}}, shreg_r};
  assign hex_ovf_s = |(ext_s >> BW);

  // Conversion datapath and display register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_r   <= '0;
      bcd_r     <= '0;
      cnt_r     <= '0;
      hex_r     <= 1'b0;
      ovf_acc_r <= 1'b0;
      disp_r    <= '0;
      valid_r   <= 1'b0;
      ovf_r     <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (load_s) begin
        shreg_r   <= bin;
        bcd_r     <= '0;
        cnt_r     <= CW'(WIDTH);
        hex_r     <= hex_mode;
        ovf_acc_r <= 1'b0;
        busy_r    <= 1'b1;
      end else if (shift_s) begin
        bcd_r     <= {adj_s[BW-2:0], shreg_r[WIDTH-1]};
        shreg_r   <= {shreg_r[WIDTH-2:0], 1'b0};
        ovf_acc_r <= ovf_acc_r | adj_s[BW-1];
        cnt_r     <= cnt_r - CW'(1);
      end else if (fin_s) begin
        disp_r  <= hex_r ? ext_s[BW-1:0] : bcd_r;
        ovf_r   <= hex_r ? hex_ovf_s : ovf_acc_r;
        valid_r <= 1'b1;
        done_r  <= 1'b1;
        busy_r  <= 1'b0;
      end else begin
        done_r <= 1'b0;
      end
    end
  end

  // Leading-zero blanking, scanned from the top digit down; digit 0 never blanks
  always_comb begin
    blank_s      = '0;
    zero_above_s = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above_s = zero_above_s & (disp_r[4*i +: 4] == 4'd0);
      if (!valid_r) begin
        blank_s[i] = 1'b1;
      end else if (blank_en && (i != 0) && zero_above_s) begin
        blank_s[i] = 1'b1;
      end else begin
        blank_s[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : gen_dig
    seg7_enc u_enc (
      .nibble (disp_r[4*g +: 4]),
      .blank  (blank_s[g]),
      .dash   (ovf_r),
      .glyph  (glyph_s[g])
    );
    assign pglyph_s[g]       = SEG_ACTIVE_LOW ? glyph_s[g] : ~glyph_s[g];
    assign seg_all[7*g +: 7] = pglyph_s[g];
  end

  assign tc_s = (presc_r == PW'(SCAN_DIV - 1));

  // Next scanned digit index
  always_comb begin
    idx_nxt_s = idx_r;
    if (tc_s) begin
      idx_nxt_s = (idx_r == IW'(DIGITS - 1)) ? '0 : idx_r + IW'(1);
    end else begin
      idx_nxt_s = idx_r;
    end
  end

  // Scan prescaler, digit index and registered segment/anode drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= '0;
      idx_r   <= '0;
      an_r    <= ~(DIGITS'(1));
      seg_r   <= SEG_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;
    end else begin
      presc_r <= tc_s ? '0 : presc_r + PW'(1);
      idx_r   <= idx_nxt_s;
      an_r    <= ~(DIGITS'(1) << idx_nxt_s);
      seg_r   <= pglyph_s[idx_nxt_s];
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign ovf  = ovf_r;
  assign seg  = seg_r;
  assign an   = an_r;

endmodule

// File: tb/tb_bin_to_7seg_mux.sv
// Bench for bin_to_7seg_mux: two instances (3 digits active-low, 2 digits inverted)
// checked every cycle against an arithmetic model, plus hand-computed glyph checks.
module tb_bin_to_7seg_mux;

  logic        clk = 1'b0;
  logic        rst, start, hex_mode, blank_en;
  logic [7:0]  bin;
  logic        busy0, done0, ovf0, busy1, done1, ovf1;
  logic [20:0] seg_all0;
  logic [13:0] seg_all1;
  logic [6:0]  seg0, seg1;
  logic [2:0]  an0;
  logic [1:0]  an1;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  bin_to_7seg_mux #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut0 (
    .clk(clk), .rst(rst), .bin(bin), .start(start), .hex_mode(hex_mode),
    .blank_en(blank_en), .busy(busy0), .done(done0), .ovf(ovf0),
    .seg_all(seg_all0), .seg(seg0), .an(an0)
  );

  bin_to_7seg_mux #(.WIDTH(8), .DIGITS(2), .SCAN_DIV(3), .SEG_ACTIVE_LOW(1'b0)) dut1 (
    .clk(clk), .rst(rst), .bin(bin), .start(start), .hex_mode(hex_mode),
    .blank_en(blank_en), .busy(busy1), .done(done1), .ovf(ovf1),
    .seg_all(seg_all1), .seg(seg1), .an(an1)
  );

  // model state, one slot per instance
  int unsigned m_cnt[2], m_v[2], m_pv[2], m_n[2];
  bit          m_hex[2], m_phex[2], m_valid[2], m_ovf[2], m_done[2];
  logic [6:0]  m_seg[2];
  logic [2:0]  m_an[2];

  function automatic int dg(int d);   return (d == 0) ? 3 : 2; endfunction
  function automatic int sdiv(int d); return (d == 0) ? 4 : 3; endfunction

  function automatic int unsigned pw(int unsigned b, int e);
    int unsigned r = 1;
    for (int k = 0; k < e; k++) r = r * b;
    return r;
  endfunction

  function automatic logic [6:0] glyph(int unsigned n);
    case (n)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [20:0] exp_all(int d);
    logic [20:0] r;
    logic [6:0]  g;
    int unsigned base, dv;
    r    = '0;
    base = m_hex[d] ? 16 : 10;
    dv   = m_hex[d] ? (m_v[d] % pw(16, dg(d))) : m_v[d];
    for (int i = 0; i < dg(d); i++) begin
      if (!m_valid[d])                               g = 7'b1111111;
      else if (m_ovf[d])                             g = 7'b0111111;
      else if (blank_en && i > 0 && dv < pw(base, i)) g = 7'b1111111;
      else                                           g = glyph((dv / pw(base, i)) % base);
      if (d == 1) g = ~g;
      r[7*i +: 7] = g;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_v[d] = 0; m_n[d] = 0; m_hex[d] = 1'b0;
      m_valid[d] = 1'b0; m_ovf[d] = 1'b0; m_done[d] = 1'b0;
      m_seg[d] = (d == 0) ? 7'b1111111 : 7'b0000000;
      m_an[d]  = 3'b110;
    end
  endtask

  task automatic model_step();
    logic [20:0] pre;
    logic [2:0]  oh;
    int          idx;
    if (rst) begin
      model_reset();
    end else begin
      for (int d = 0; d < 2; d++) begin
        pre     = exp_all(d);
        m_n[d]  = m_n[d] + 1;
        idx     = (m_n[d] / sdiv(d)) % dg(d);
        oh      = 3'b001 << idx;
        m_an[d] = ~oh;
        m_seg[d] = pre[7*idx +: 7];
        m_done[d] = 1'b0;
        if (m_cnt[d] > 0) begin
          m_cnt[d] = m_cnt[d] - 1;
          if (m_cnt[d] == 0) begin
            m_done[d]  = 1'b1;
            m_valid[d] = 1'b1;
            m_v[d]     = m_pv[d];
            m_hex[d]   = m_phex[d];
            m_ovf[d]   = m_phex[d] ? (m_pv[d] >= pw(16, dg(d))) : (m_pv[d] >= pw(10, dg(d)));
          end
        end else if (start) begin
          m_pv[d]   = bin;
          m_phex[d] = hex_mode;
          m_cnt[d]  = hex_mode ? 1 : 9;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    else passes++;
  endtask

  task automatic compare_all();
    logic [20:0] e0, e1;
    e0 = exp_all(0);
    e1 = exp_all(1);
    chk("busy0", 32'(busy0), 32'(m_cnt[0] != 0));
    chk("done0", 32'(done0), 32'(m_done[0]));
    chk("ovf0", 32'(ovf0), 32'(m_ovf[0]));
    chk("seg_all0", 32'(seg_all0), 32'(e0));
    chk("an0", 32'(an0), 32'(m_an[0]));
    chk("seg0", 32'(seg0), 32'(m_seg[0]));
    chk("busy1", 32'(busy1), 32'(m_cnt[1] != 0));
    chk("done1", 32'(done1), 32'(m_done[1]));
    chk("ovf1", 32'(ovf1), 32'(m_ovf[1]));
    chk("seg_all1", 32'(seg_all1), 32'(e1[13:0]));
    chk("an1", 32'(an1), 32'(m_an[1][1:0]));
    chk("seg1", 32'(seg1), 32'(m_seg[1]));
  endtask

  // compare at the falling edge, advance the model on the rising edge, drive inputs 2 units later
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic conv(input int v, input bit hx, input int lat);
    int c;
    bin = 8'(v); hex_mode = hx; start = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (!done0 && c < 40) begin
      tick();
      c++;
    end
    chk("latency", 32'(c), 32'(lat));
  endtask

  initial begin
    int cnt;
    logic [2:0] an_prev;
    rst = 1'b1; start = 1'b0; bin = 8'd0; hex_mode = 1'b0; blank_en = 1'b0;
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_seg_all0", 32'(seg_all0), 32'h1FFFFF);
    chk("rst_seg_all1", 32'(seg_all1), 32'h0);
    chk("rst_an0", 32'(an0), 32'(3'b110));
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_done0", 32'(done0), 32'd0);
    repeat (3) tick();

    conv(255, 1'b0, 9);
    chk("dec255", 32'(seg_all0), 32'(21'b0100100_0010010_0010010));
    chk("dec255_ovf", 32'(ovf0), 32'd0);
    tick();

    blank_en = 1'b1;
    conv(7, 1'b0, 9);
    chk("blank7", 32'(seg_all0), 32'(21'b1111111_1111111_1111000));
    conv(0, 1'b0, 9);
    chk("blank0", 32'(seg_all0), 32'(21'b1111111_1111111_1000000));

    blank_en = 1'b0;
    conv(100, 1'b0, 9);
    chk("ovf100", 32'(ovf1), 32'd1);
    chk("dash100", 32'(seg_all1), 32'(14'b1000000_1000000));
    chk("dec100_d3", 32'(seg_all0), 32'(21'b1111001_1000000_1000000));
    blank_en = 1'b1;
    tick();
    chk("dash_noblank", 32'(seg_all1), 32'(14'b1000000_1000000));
    blank_en = 1'b0;
    conv(99, 1'b0, 9);
    chk("ovf99", 32'(ovf1), 32'd0);
    chk("dec99", 32'(seg_all1), 32'(14'b1101111_1101111));

    conv(8'hAB, 1'b1, 1);
    chk("hexAB", 32'(seg_all0), 32'(21'b1000000_0001000_0000011));
    blank_en = 1'b1;
    tick();
    chk("hexAB_blank", 32'(seg_all0), 32'(21'b1111111_0001000_0000011));
    blank_en = 1'b0;

    // second start during a decimal conversion must be dropped
    bin = 8'd42; hex_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    bin = 8'd200; hex_mode = 1'b1; start = 1'b1;
    repeat (2) tick();
    start = 1'b0;
    cnt = 0;
    repeat (25) begin
      tick();
      if (done0) cnt++;
    end
    chk("single_done", 32'(cnt), 32'd1);
    chk("dec42", 32'(seg_all0), 32'(21'b1000000_0011001_0100100));

    // start held high: back-to-back conversions every 10 cycles
    bin = 8'd123; hex_mode = 1'b0; start = 1'b1;
    cnt = 0;
    repeat (30) begin
      tick();
      if (done0) cnt++;
    end
    start = 1'b0;
    chk("held_start", 32'(cnt), 32'd3);
    repeat (10) tick();

    cnt = 0;
    an_prev = an0;
    repeat (24) begin
      tick();
      if (an0 != an_prev) cnt++;
      an_prev = an0;
    end
    chk("scan_rate", 32'(cnt), 32'd6);

    // reset in the middle of a decimal conversion
    bin = 8'd55; hex_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_async_busy", 32'(busy0), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    cnt = 0;
    repeat (15) begin
      tick();
      if (done0) cnt++;
    end
    chk("rst_no_done", 32'(cnt), 32'd0);
    chk("rst_blank", 32'(seg_all0), 32'h1FFFFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
